load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 39 +++
 rtl/lsu_align.sv | 76 +++++++
 rtl/load_store_unit.sv | 178 +++++++++++++++++
 tb/tb_load_store_unit.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
//   - RISC-V funct3 size/sign codes
//   - FSM state enumeration
//   - helpers: access size in bytes, illegal-code detection
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE0,
    ST_WAIT0,
    ST_ISSUE1,
    ST_WAIT1,
    ST_RESP
  } state_e;

  // Access size in bytes; the low two funct3 bits encode log2(size).
  function automatic logic [3:0] size_bytes(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 4'd1;
      2'b01:   return 4'd2;
      2'b10:   return 4'd4;
      default: return 4'd8;
    endcase
  endfunction

  // 111 is never legal; doubleword and WU only exist on a 64-bit bus.
  function automatic logic is_illegal(input logic [2:0] f3, input int dw);
    return (f3 == 3'b111) || ((dw == 32) && ((f3 == F3_D) || (f3 == F3_WU)));
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane alignment for the load/store unit.
// Ports:
//   off_i       byte offset of the access inside the bus word
//   funct3_i    size/sign code
//   beat1_i     1 selects the second (upper) beat of a split access
//   wdata_i     LSB-aligned store data
//   rdata_lo_i  bus word holding the first addressed byte
//   rdata_hi_i  following bus word (only meaningful for split loads)
//   wstrb_o     byte enables for the selected beat
//   wdata_o     lane-shifted store data for the selected beat
//   rdata_o     extracted and sign/zero-extended load result
module lsu_align
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  localparam int NB   = DATA_WIDTH / 8,
  localparam int OFFW = $clog2(NB)
) (
  input  logic [OFFW-1:0]       off_i,
  input  logic [2:0]            funct3_i,
  input  logic                  beat1_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [DATA_WIDTH-1:0] rdata_lo_i,
  input  logic [DATA_WIDTH-1:0] rdata_hi_i,
  output logic [NB-1:0]         wstrb_o,
  output logic [DATA_WIDTH-1:0] wdata_o,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [2*NB-1:0]         mask_base;
  logic [2*NB-1:0]         mask_wide;
  logic [2*DATA_WIDTH-1:0] wdata_wide;
  logic [DATA_WIDTH-1:0]   lane;
  logic                    sign_bit;
  int                      nbits;

  // Store side: build a two-word-wide image of the access so that the
  // upper word is exactly what a second beat needs at lane 0.
  always_comb begin
    mask_base = '0;
    for (int i = 0; i < 2*NB; i++) begin
      if (i < int'(size_bytes(funct3_i))) mask_base[i] = 1'b1;
    end
    mask_wide  = mask_base << off_i;
    wdata_wide = {{DATA_WIDTH{1'b0}}, wdata_i} << {off_i, 3'b000};
    wstrb_o    = beat1_i ? mask_wide[2*NB-1:NB] : mask_wide[NB-1:0];
    wdata_o    = beat1_i ? wdata_wide[2*DATA_WIDTH-1:DATA_WIDTH]
                         : wdata_wide[DATA_WIDTH-1:0];
  end

  // Load side: concatenating the two beats and shifting right merges the
  // upper bytes of beat0 with the lower bytes of beat1.
  always_comb begin
    lane  = DATA_WIDTH'({rdata_hi_i, rdata_lo_i} >> {off_i, 3'b000});
    nbits = int'(size_bytes(funct3_i)) * 8;
    if (nbits > DATA_WIDTH) nbits = DATA_WIDTH;
    case (size_bytes(funct3_i))
      4'd1:    sign_bit = lane[7];
      4'd2:    sign_bit = lane[15];
      4'd4:    sign_bit = lane[31];
      default: sign_bit = lane[DATA_WIDTH-1];
    endcase
    // BU/HU/WU have funct3[2] set and zero-extend.
    if ((funct3_i == F3_BU) || (funct3_i == F3_HU) || (funct3_i == F3_WU)) begin
      sign_bit = 1'b0;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_ext
      assign rdata_o[gi] = (gi < nbits) ? lane[gi] : sign_bit;
    end
  endgenerate

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one byte/half/word(/double) request, issues one
// or two aligned bus beats, and returns an extended load result or error.
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   req_*                  CPU request (valid/ready, we, funct3, addr, wdata)
//   mem_req_*, mem_addr_o, mem_we_o, mem_wstrb_o, mem_wdata_o
//                          aligned bus request channel
//   mem_rvalid_i, mem_rdata_i  bus read-data return
//   rsp_*                  completion (valid/ready, data, err)
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH       = 32,
  parameter int ADDR_WIDTH       = 32,
  parameter int SPLIT_MISALIGNED = 1,
  localparam int NB   = DATA_WIDTH / 8,
  localparam int OFFW = $clog2(NB)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [2:0]            req_funct3_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  mem_req_valid_o,
  input  logic                  mem_req_ready_i,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic                  mem_we_o,
  output logic [NB-1:0]         mem_wstrb_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic                  mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_data_o,
  output logic                  rsp_err_o
);

  state_e                state_q, state_d;
  logic                  we_q;
  logic [2:0]            funct3_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  split_q;
  logic [DATA_WIDTH-1:0] rdata0_q;
  logic [DATA_WIDTH-1:0] rsp_data_q;
  logic                  rsp_err_q;

  logic                  accept;
  logic                  cross_in;
  logic                  err_in;
  logic                  issuing;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [NB-1:0]         align_wstrb;
  logic [DATA_WIDTH-1:0] align_wdata;
  logic [DATA_WIDTH-1:0] align_rdata;
  logic [DATA_WIDTH-1:0] rdata_lo;

  // Classification of the incoming request, decided at accept time.
  always_comb begin
    accept   = (state_q == ST_IDLE) && req_valid_i;
    cross_in = (int'(req_addr_i[OFFW-1:0]) + int'(size_bytes(req_funct3_i))) > NB;
    err_in   = is_illegal(req_funct3_i, DATA_WIDTH) ||
               (cross_in && (SPLIT_MISALIGNED == 0));
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = err_in ? ST_RESP : ST_ISSUE0;
      end
      ST_ISSUE0: begin
        if (mem_req_ready_i) begin
          if (!we_q)       state_d = ST_WAIT0;
          else if (split_q) state_d = ST_ISSUE1;
          else             state_d = ST_RESP;
        end
      end
      ST_WAIT0: begin
        if (mem_rvalid_i) state_d = split_q ? ST_ISSUE1 : ST_RESP;
      end
      ST_ISSUE1: begin
        if (mem_req_ready_i) state_d = we_q ? ST_RESP : ST_WAIT1;
      end
      ST_WAIT1: begin
        if (mem_rvalid_i) state_d = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs. Bus fields come straight from registered request state so
  // they cannot change while a beat is stalled; they read zero when idle.
  always_comb begin
    issuing         = (state_q == ST_ISSUE0) || (state_q == ST_ISSUE1);
    base_addr       = {addr_q[ADDR_WIDTH-1:OFFW], {OFFW{1'b0}}};
    req_ready_o     = (state_q == ST_IDLE);
    mem_req_valid_o = issuing;
    mem_addr_o      = '0;
    mem_we_o        = 1'b0;
    mem_wstrb_o     = '0;
    mem_wdata_o     = '0;
    if (issuing) begin
      mem_addr_o = (state_q == ST_ISSUE1) ? base_addr + ADDR_WIDTH'(NB) : base_addr;
      mem_we_o   = we_q;
      if (we_q) begin
        mem_wstrb_o = align_wstrb;
        mem_wdata_o = align_wdata;
      end
    end
    rsp_valid_o = (state_q == ST_RESP);
    rsp_data_o  = (state_q == ST_RESP) ? rsp_data_q : '0;
    rsp_err_o   = (state_q == ST_RESP) ? rsp_err_q  : 1'b0;
  end

  // For a split load the first beat was captured earlier; otherwise the
  // live bus word is the one holding the addressed bytes.
  assign rdata_lo = (state_q == ST_WAIT1) ? rdata0_q : mem_rdata_i;

  lsu_align #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_align (
    .off_i      (addr_q[OFFW-1:0]),
    .funct3_i   (funct3_q),
    .beat1_i    (state_q == ST_ISSUE1),
    .wdata_i    (wdata_q),
    .rdata_lo_i (rdata_lo),
    .rdata_hi_i (mem_rdata_i),
    .wstrb_o    (align_wstrb),
    .wdata_o    (align_wdata),
    .rdata_o    (align_rdata)
  );

  // Request and response datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      we_q       <= 1'b0;
      funct3_q   <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      split_q    <= 1'b0;
      rdata0_q   <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      if (accept) begin
        we_q       <= req_we_i;
        funct3_q   <= req_funct3_i;
        addr_q     <= req_addr_i;
        wdata_q    <= req_wdata_i;
        split_q    <= cross_in;
        rsp_data_q <= '0;
        rsp_err_q  <= err_in;
      end
      if ((state_q == ST_WAIT0) && mem_rvalid_i) begin
        rdata0_q <= mem_rdata_i;
        if (!split_q) rsp_data_q <= align_rdata;
      end
      if ((state_q == ST_WAIT1) && mem_rvalid_i) begin
        rsp_data_q <= align_rdata;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int NB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          req_valid, req_we, req_ready;
  logic [2:0]    req_funct3;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          mem_req_valid, mem_req_ready, mem_we, mem_rvalid;
  logic [AW-1:0] mem_addr;
  logic [NB-1:0] mem_wstrb;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [DW-1:0] rsp_data;

  // Second instance with splitting disabled.
  logic          req_valid2, req_ready2, rsp_ready2;
  logic          mem_req_valid2, mem_we2, rsp_valid2, rsp_err2;
  logic [AW-1:0] mem_addr2;
  logic [NB-1:0] mem_wstrb2;
  logic [DW-1:0] mem_wdata2, rsp_data2;

  load_store_unit #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SPLIT_MISALIGNED(1)) u_dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_funct3_i(req_funct3), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .mem_req_valid_o(mem_req_valid), .mem_req_ready_i(mem_req_ready),
    .mem_addr_o(mem_addr), .mem_we_o(mem_we), .mem_wstrb_o(mem_wstrb),
    .mem_wdata_o(mem_wdata), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_data_o(rsp_data), .rsp_err_o(rsp_err)
  );

  load_store_unit #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SPLIT_MISALIGNED(0)) u_dut_ns (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid2), .req_ready_o(req_ready2), .req_we_i(req_we),
    .req_funct3_i(req_funct3), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .mem_req_valid_o(mem_req_valid2), .mem_req_ready_i(mem_req_ready),
    .mem_addr_o(mem_addr2), .mem_we_o(mem_we2), .mem_wstrb_o(mem_wstrb2),
    .mem_wdata_o(mem_wdata2), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
    .rsp_valid_o(rsp_valid2), .rsp_ready_i(rsp_ready2),
    .rsp_data_o(rsp_data2), .rsp_err_o(rsp_err2)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  strb;
    logic [31:0] wdata;
  } beat_t;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } rsp_t;

  beat_t beat_q[$];
  rsp_t  rsp_q[$];
  rsp_t  rsp2_q[$];
  beat_t eb;
  rsp_t  er;

  int checks = 0;
  int passes = 0;
  int busv_cnt = 0;
  int busv_cnt2 = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [103:0] outs();
    return {mem_req_valid, mem_addr, mem_we, mem_wstrb, mem_wdata, rsp_valid, rsp_data, rsp_err};
  endfunction

  // Monitors: compare bus beats and responses against the expected queues.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_req_valid) busv_cnt++;
      if (mem_req_valid2) busv_cnt2++;
      if (mem_req_valid && mem_req_ready) begin
        if (beat_q.size() == 0) chk("bus_unexpected", 1, 0);
        else begin
          eb = beat_q.pop_front();
          chk("bus_addr", mem_addr, eb.addr);
          chk("bus_we", mem_we, eb.we);
          if (eb.we) begin
            chk("bus_wstrb", mem_wstrb, eb.strb);
            chk("bus_wdata", mem_wdata, eb.wdata);
          end
          $display("bus beat addr=0x%0h we=%0b strb=%b wdata=0x%0h", mem_addr, mem_we, mem_wstrb, mem_wdata);
        end
      end
      if (rsp_valid && rsp_ready) begin
        if (rsp_q.size() == 0) chk("rsp_unexpected", 1, 0);
        else begin
          er = rsp_q.pop_front();
          chk("rsp_data", rsp_data, er.data);
          chk("rsp_err", rsp_err, er.err);
          $display("rsp data=0x%0h err=%0b", rsp_data, rsp_err);
        end
      end
      if (rsp_valid2 && rsp_ready2) begin
        if (rsp2_q.size() == 0) chk("rsp2_unexpected", 1, 0);
        else begin
          er = rsp2_q.pop_front();
          chk("rsp2_data", rsp_data2, er.data);
          chk("rsp2_err", rsp_err2, er.err);
          $display("rsp(nosplit) data=0x%0h err=%0b", rsp_data2, rsp_err2);
        end
      end
    end
  end

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd);
    @(posedge clk); #1;
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // Serve one bus beat: optional stall with stability checks, then optional read data.
  task automatic serve(input int stall, input logic is_load, input logic [31:0] rd,
                       input int rlat, input logic expect_rsp_next);
    int t = 0;
    logic [68:0] snap;
    while (!mem_req_valid && t < 20) begin @(posedge clk); #1; t++; end
    if (!mem_req_valid) begin chk("bus_timeout", 0, 1); return; end
    snap = {mem_addr, mem_we, mem_wstrb, mem_wdata};
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      chk("bus_stable", {mem_req_valid, mem_addr, mem_we, mem_wstrb, mem_wdata}, {1'b1, snap});
    end
    mem_req_ready = 1'b1;
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    if (expect_rsp_next) chk("rsp_after_store_beat", rsp_valid, 1);
    if (is_load) begin
      for (int i = 0; i < rlat; i++) begin @(posedge clk); #1; end
      mem_rvalid = 1'b1; mem_rdata = rd;
      @(posedge clk); #1;
      mem_rvalid = 1'b0; mem_rdata = '0;
    end
  endtask

  task automatic take_rsp(input int hold);
    int t = 0;
    logic [32:0] snap;
    while (!rsp_valid && t < 20) begin @(posedge clk); #1; t++; end
    if (!rsp_valid) begin chk("rsp_timeout", 0, 1); return; end
    snap = {rsp_data, rsp_err};
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("rsp_hold", {rsp_valid, rsp_data, rsp_err, mem_req_valid}, {1'b1, snap, 1'b0});
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("idle_after_rsp", req_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0; req_addr = '0;
    req_wdata = '0; mem_req_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    rsp_ready = 1'b0; req_valid2 = 1'b0; rsp_ready2 = 1'b0;

    #2;
    chk("reset_outputs", outs(), 104'h0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("reset_req_ready", req_ready, 1);

    // LB 0x103: byte 0x80 sign-extends.
    beat_q.push_back('{32'h100, 1'b0, 4'h0, 32'h0});
    rsp_q.push_back('{32'hFFFFFF80, 1'b0});
    issue(1'b0, 3'b000, 32'h103, 32'h0);
    chk("issue_next_cycle", mem_req_valid, 1);
    serve(0, 1'b1, 32'h80FF0000, 1, 1'b0);
    take_rsp(0);

    // SH 0x202.
    beat_q.push_back('{32'h200, 1'b1, 4'b1100, 32'hABCD0000});
    rsp_q.push_back('{32'h0, 1'b0});
    issue(1'b1, 3'b001, 32'h202, 32'h1234ABCD);
    serve(0, 1'b0, 32'h0, 0, 1'b1);
    take_rsp(0);

    // LW 0x105 split over 0x104/0x108.
    beat_q.push_back('{32'h104, 1'b0, 4'h0, 32'h0});
    beat_q.push_back('{32'h108, 1'b0, 4'h0, 32'h0});
    rsp_q.push_back('{32'h55443322, 1'b0});
    issue(1'b0, 3'b010, 32'h105, 32'h0);
    serve(0, 1'b1, 32'h44332211, 0, 1'b0);
    serve(1, 1'b1, 32'h88776655, 2, 1'b0);
    take_rsp(0);

    // SW 0x10 with 3 stall cycles and 2 cycles of response backpressure.
    beat_q.push_back('{32'h10, 1'b1, 4'hF, 32'hDEADBEEF});
    rsp_q.push_back('{32'h0, 1'b0});
    issue(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
    serve(3, 1'b0, 32'h0, 0, 1'b1);
    take_rsp(2);

    // Split store SW 0x0E.
    beat_q.push_back('{32'h0C, 1'b1, 4'b1100, 32'hC3D40000});
    beat_q.push_back('{32'h10, 1'b1, 4'b0011, 32'h0000A1B2});
    rsp_q.push_back('{32'h0, 1'b0});
    issue(1'b1, 3'b010, 32'h0E, 32'hA1B2C3D4);
    serve(0, 1'b0, 32'h0, 0, 1'b0);
    serve(0, 1'b0, 32'h0, 0, 1'b1);
    take_rsp(0);

    // LH 0x101 (sign) then a stray rvalid in IDLE, then LBU 0x102 (zero).
    beat_q.push_back('{32'h100, 1'b0, 4'h0, 32'h0});
    rsp_q.push_back('{32'hFFFFABCD, 1'b0});
    issue(1'b0, 3'b001, 32'h101, 32'h0);
    serve(0, 1'b1, 32'h12ABCD34, 0, 1'b0);
    take_rsp(0);
    mem_rvalid = 1'b1; mem_rdata = 32'hFFFFFFFF;
    @(posedge clk); #1;
    mem_rvalid = 1'b0; mem_rdata = '0;
    beat_q.push_back('{32'h100, 1'b0, 4'h0, 32'h0});
    rsp_q.push_back('{32'h000000AB, 1'b0});
    issue(1'b0, 3'b100, 32'h102, 32'h0);
    serve(0, 1'b1, 32'h12ABCD34, 1, 1'b0);
    take_rsp(0);

    // Illegal codes: 011 and 110 on a 32-bit bus, 111 always.
    for (int k = 0; k < 3; k++) begin
      logic [2:0] f3;
      f3 = (k == 0) ? 3'b011 : (k == 1) ? 3'b110 : 3'b111;
      rsp_q.push_back('{32'h0, 1'b1});
      c = busv_cnt;
      issue(k == 2, f3, 32'h20, 32'h55);
      chk("err_rsp_latency", {rsp_valid, rsp_err, mem_req_valid}, 3'b110);
      take_rsp(0);
      chk("no_bus_on_err", busv_cnt, c);
    end

    // Misaligned LW on the non-splitting instance.
    rsp2_q.push_back('{32'h0, 1'b1});
    c = busv_cnt2;
    @(posedge clk); #1;
    req_valid2 = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h105;
    @(posedge clk); #1;
    req_valid2 = 1'b0;
    chk("nosplit_err_rsp", {rsp_valid2, rsp_err2}, 2'b11);
    rsp_ready2 = 1'b1;
    @(posedge clk); #1;
    rsp_ready2 = 1'b0;
    chk("nosplit_no_bus", busv_cnt2, c);
    chk("nosplit_idle", req_ready2, 1);

    // Reset while waiting for the second beat of a split load.
    beat_q.push_back('{32'h104, 1'b0, 4'h0, 32'h0});
    beat_q.push_back('{32'h108, 1'b0, 4'h0, 32'h0});
    issue(1'b0, 3'b010, 32'h105, 32'h0);
    serve(0, 1'b1, 32'h44332211, 0, 1'b0);
    chk("beat1_issued", {mem_req_valid, mem_addr}, {1'b1, 32'h108});
    mem_req_ready = 1'b1;
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", outs(), 104'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'h88776655;
    @(posedge clk); #1;
    mem_rvalid = 1'b0; mem_rdata = '0;
    for (int i = 0; i < 3; i++) begin
      chk("post_reset_idle", {req_ready, outs()}, {1'b1, 104'h0});
      @(posedge clk); #1;
    end

    chk("scoreboard_drained", beat_q.size() + rsp_q.size() + rsp2_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
